// File: rtl/cgra_clkgate_ctrl.sv
// Clock-gate enable controller for a CGRA array: wakes on host/bus activity,
// auto-gates after a programmable idle period, and honours software sleep/force.
module cgra_clkgate_ctrl #(
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             busy_i,
  input  logic             force_en_i,
  input  logic             sleep_req_i,
  input  logic [CNT_W-1:0] idle_thresh_i,
  output logic             en_o,
  output logic             ready_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] GATED  = 2'd0;
  localparam logic [1:0] WAKE   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  localparam logic [1:0] IDLE   = 2'd3;

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       wake_cnt_q, wake_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;

  logic             act;
  logic [CNT_W:0]   idle_next;
  logic             thresh_hit;

  assign act       = req_i | busy_i | force_en_i;
  assign idle_next = {1'b0, idle_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  // Compare with >= so a threshold lowered below the running count gates at once.
  assign thresh_hit = (idle_thresh_i != '0) && (idle_next >= {1'b0, idle_thresh_i});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= GATED;
      wake_cnt_q <= '0;
      idle_cnt_q <= '0;
      en_q       <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      en_q       <= en_d;
      ready_q    <= ready_d;
    end
  end

  // Counters default to zero so they are cleared whenever their state is (re)entered.
  always_comb begin
    state_d    = state_q;
    wake_cnt_d = '0;
    idle_cnt_d = '0;
    case (state_q)
      GATED: begin
        if (act) state_d = WAKE;
      end
      WAKE: begin
        if (wake_cnt_q == WAKE_LAST) state_d = ACTIVE;
        else                         wake_cnt_d = wake_cnt_q + 4'd1;
      end
      ACTIVE: begin
        if (!act) state_d = sleep_req_i ? GATED : IDLE;
      end
      IDLE: begin
        if (act) begin
          state_d = ACTIVE;
        end else if (sleep_req_i || thresh_hit) begin
          state_d = GATED;
        end else begin
          idle_cnt_d = (&idle_cnt_q) ? idle_cnt_q : idle_next[CNT_W-1:0];
        end
      end
      default: state_d = GATED;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as state_q.
  always_comb begin
    en_d    = (state_d != GATED);
    ready_d = (state_d == ACTIVE) || (state_d == IDLE);
  end

  assign en_o    = en_q;
  assign ready_o = ready_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_cgra_clkgate_ctrl.sv
// Directed scoreboard bench for cgra_clkgate_ctrl: stimulus pushes per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_cgra_clkgate_ctrl;

  localparam logic [1:0] G = 2'd0;
  localparam logic [1:0] W = 2'd1;
  localparam logic [1:0] A = 2'd2;
  localparam logic [1:0] I = 2'd3;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       req_i, busy_i, force_en_i, sleep_req_i;
  logic [7:0] idle_thresh_i;
  logic       en_o, ready_o;
  logic [1:0] state_o;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_st_q  [$];
  logic [7:0] exp_cnt_q [$];
  string      exp_nm_q  [$];

  cgra_clkgate_ctrl #(.WAKE_CYCLES(2), .CNT_W(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .busy_i       (busy_i),
    .force_en_i   (force_en_i),
    .sleep_req_i  (sleep_req_i),
    .idle_thresh_i(idle_thresh_i),
    .en_o         (en_o),
    .ready_o      (ready_o),
    .state_o      (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act_v, exp_v, $time);
    end
  endtask

  // Monitor: every settled cycle with a pending expectation is compared.
  always @(negedge clk_i) begin
    if (exp_st_q.size() > 0) begin
      logic [1:0] es;
      logic [7:0] ec;
      string      nm;
      es = exp_st_q.pop_front();
      ec = exp_cnt_q.pop_front();
      nm = exp_nm_q.pop_front();
      check({nm, ".state"}, 32'(state_o), 32'(es));
      check({nm, ".en"},    32'(en_o),    32'(es != G));
      check({nm, ".ready"}, 32'(ready_o), 32'(es == A || es == I));
      check({nm, ".cnt"},   32'(dut.idle_cnt_q), 32'(ec));
    end
  end

  // Drive inputs for one edge and queue the state/counter expected after it.
  task automatic step(input logic r, input logic b, input logic f, input logic s,
                      input logic [7:0] thr, input logic [1:0] est,
                      input logic [7:0] ecnt, input string nm);
    req_i = r; busy_i = b; force_en_i = f; sleep_req_i = s; idle_thresh_i = thr;
    exp_st_q.push_back(est);
    exp_cnt_q.push_back(ecnt);
    exp_nm_q.push_back(nm);
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    req_i = 0; busy_i = 0; force_en_i = 0; sleep_req_i = 0; idle_thresh_i = 8'd4;
    #3;
    check("rst.state", 32'(state_o), 32'(G));
    check("rst.en",    32'(en_o),    0);
    check("rst.ready", 32'(ready_o), 0);
    @(negedge clk_i); #1;
    rst_ni = 1'b1;

    repeat (2) step(0,0,0,0,8'd4, G,0,"quiet");
    step(0,0,0,1,8'd4, G,0,"gated_sleep_ignored");

    // Wake by one-cycle req pulse, then auto-gate after 4 idle cycles.
    step(1,0,0,0,8'd4, W,0,"wake_req");
    step(0,0,0,0,8'd4, W,0,"wake_hold");
    step(0,0,0,0,8'd4, A,0,"wake_done");
    step(0,0,0,0,8'd4, I,0,"idle_entry");
    step(0,0,0,0,8'd4, I,1,"idle1");
    step(0,0,0,0,8'd4, I,2,"idle2");
    step(0,0,0,0,8'd4, I,3,"idle3");
    step(0,0,0,0,8'd4, G,0,"autogate");

    // Busy-driven activity, busy falls in ACTIVE.
    step(0,1,0,0,8'd4, W,0,"busy_wake");
    step(0,1,0,0,8'd4, W,0,"busy_wake2");
    step(0,1,0,0,8'd4, A,0,"busy_act");
    step(0,1,0,1,8'd4, A,0,"sleep_vs_busy");
    step(1,0,0,1,8'd4, A,0,"sleep_vs_req");
    step(0,0,0,0,8'd4, I,0,"busy_fall");
    step(0,0,0,0,8'd4, I,1,"b_idle1");
    step(0,0,0,0,8'd4, I,2,"b_idle2");
    step(1,0,0,1,8'd4, A,0,"idle_abort");
    step(0,0,0,1,8'd4, G,0,"sleep_active");

    // Sleep from IDLE, then lowered threshold gates at once.
    step(1,0,0,0,8'd0, W,0,"w2");
    step(0,0,0,0,8'd0, W,0,"w2b");
    step(0,0,0,0,8'd0, A,0,"w2c");
    step(0,0,0,0,8'd0, I,0,"i2");
    step(0,0,0,1,8'd0, G,0,"sleep_idle");
    step(0,0,1,0,8'd0, W,0,"w3");
    step(0,0,0,0,8'd0, W,0,"w3b");
    step(0,0,0,0,8'd0, A,0,"w3c");
    step(0,0,0,0,8'd0, I,0,"i3");
    for (int k = 1; k <= 5; k++) step(0,0,0,0,8'd0, I,8'(k),"i3_cnt");
    step(0,0,0,0,8'd3, G,0,"thresh_lowered");

    // Threshold 0: never gates, counter saturates.
    step(1,0,0,0,8'd0, W,0,"w4");
    step(0,0,0,0,8'd0, W,0,"w4b");
    step(0,0,0,0,8'd0, A,0,"w4c");
    step(0,0,0,0,8'd0, I,0,"i4");
    for (int k = 1; k <= 300; k++) step(0,0,0,0,8'd0, I,(k > 255) ? 8'd255 : 8'(k),"sat");
    step(0,0,0,0,8'd1, G,0,"sat_then_thr1");

    // Force keeps the clock on despite sleep and threshold 1.
    step(0,0,1,0,8'd1, W,0,"force_wake");
    step(0,0,1,1,8'd1, W,0,"force_wake2");
    step(0,0,1,1,8'd1, A,0,"force_act");
    for (int k = 0; k < 20; k++) step(0,0,1,1,8'd1, A,0,"force_hold");
    step(0,0,0,0,8'd1, I,0,"force_drop");
    step(0,0,0,0,8'd1, G,0,"thr1_gate");

    // Asynchronous reset mid-WAKE.
    step(1,0,0,0,8'd4, W,0,"w5");
    req_i = 0;
    rst_ni = 1'b0;
    #1;
    check("async_rst.en",    32'(en_o), 0);
    check("async_rst.state", 32'(state_o), 32'(G));
    check("async_rst.ready", 32'(ready_o), 0);
    @(posedge clk_i); @(negedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (3) step(0,0,0,0,8'd4, G,0,"post_rst");

    check("queue_drained", 32'(exp_st_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cgra_clkgate_ctrl.md
CGRA_CLKGATE_CTRL -- requirements
Module: cgra_clkgate_ctrl

Interface
REQ-001 SHALL have parameter WAKE_CYCLES, default 2, meaning cycles from en_o rise to ready_o rise (legal range 1..15).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the idle threshold and idle counter.
REQ-003 SHALL have port clk_i, input, 1 bit: the single ungated free-running clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port req_i, input, 1 bit: host/bus access pending to the CGRA.
REQ-006 SHALL have port busy_i, input, 1 bit: CGRA is executing.
REQ-007 SHALL have port force_en_i, input, 1 bit: software keep-clock-on.
REQ-008 SHALL have port sleep_req_i, input, 1 bit: software gate-now request.
REQ-009 SHALL have port idle_thresh_i, input, CNT_W bits: idle cycles before auto-gating; 0 disables auto-gating.
REQ-010 SHALL have port en_o, output, 1 bit: drives the clock-gate cell enable.
REQ-011 SHALL have port ready_o, output, 1 bit: gated clock is stable and the CGRA may be accessed.
REQ-012 SHALL have port state_o, output, 2 bits: current FSM state.

Function
REQ-013 SHALL implement an FSM with states GATED=0, WAKE=1, ACTIVE=2, IDLE=3; state_o SHALL equal the state register.
REQ-014 SHALL generate en_o and ready_o from registers: en_o=1 in WAKE/ACTIVE/IDLE; ready_o=1 in ACTIVE/IDLE only.
REQ-015 Define act = req_i | busy_i | force_en_i.
REQ-016 In GATED: act=1 -> WAKE on the next edge; otherwise remain GATED; sleep_req_i ignored.
REQ-017 In WAKE: the wake counter SHALL count from 0; after exactly WAKE_CYCLES cycles in WAKE, transition to ACTIVE regardless of act or sleep_req_i.
REQ-018 Wake latency: act sampled high at edge N (state GATED) -> en_o=1 after edge N, ready_o=1 after edge N+WAKE_CYCLES.
REQ-019 In ACTIVE: act=1 -> stay; act=0 and sleep_req_i=1 -> GATED; act=0 and sleep_req_i=0 -> IDLE with idle counter cleared to 0.
REQ-020 In IDLE: act=1 -> ACTIVE (counter cleared) with priority over all else; else sleep_req_i=1 -> GATED; else if idle_thresh_i!=0 and counter+1 == idle_thresh_i -> GATED; else counter increments (saturating at all-ones) and stay IDLE.
REQ-021 Auto-gate timing: entry into IDLE at edge M with act held low and threshold T>0 -> GATED (en_o=0) after edge M+T.
REQ-022 req_i SHALL take priority over sleep_req_i in every state; busy_i=1 SHALL block any transition to GATED.
REQ-023 idle_thresh_i SHALL be sampled every cycle; lowering it below the current count SHALL not gate until the saturating counter wraps is impossible, so the block SHALL gate immediately when counter+1 >= idle_thresh_i (compare is >=, T>0).
REQ-024 en_o and ready_o SHALL fall on the same edge when entering GATED; en_o SHALL never toggle more than once per cycle.
REQ-025 WAKE_CYCLES and idle counters SHALL be cleared whenever their state is entered.

Reset
REQ-026 While rst_ni=0: state=GATED, en_o=0, ready_o=0, state_o=0, both counters=0, asynchronously.
REQ-027 Reset asserted mid-WAKE/ACTIVE/IDLE SHALL return immediately to GATED with en_o=0; release SHALL resume normal sampling at the first rising edge after deassertion.

Verification
REQ-028 Wake: reset, WAKE_CYCLES=2, pulse req_i 1 cycle at edge 5 -> en_o=1 from edge 5, ready_o=1 from edge 7, state_o 0->1->2->3.
REQ-029 Auto-gate: idle_thresh_i=4, busy_i falls at edge 20 in ACTIVE -> IDLE at 20, GATED (en_o=0, ready_o=0) at edge 24.
REQ-030 Idle abort: idle_thresh_i=4, in IDLE count 2, req_i=1 -> ACTIVE next edge, counter 0, en_o stays 1 throughout.
REQ-031 Sleep vs busy/req: sleep_req_i=1 with busy_i=1 -> stays ACTIVE; with req_i=1 -> stays ACTIVE; with act=0 -> GATED next edge.
REQ-032 Threshold 0 / force: idle_thresh_i=0, act=0 for 300 cycles -> remains IDLE, counter saturates at 255; force_en_i=1 from GATED -> wakes and never gates while high.
REQ-033 Async reset in WAKE at cycle 1 -> en_o=0 without clock edge; after release with act=0 -> remains GATED.
